// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by an on-chip SRAM of 64-bit words.
// Read and write channels run independent FSMs with programmable latencies.
// Every beat is range-checked on its own; out-of-range beats return DECERR.
module axi4_sram_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                MEM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                R_LAT     = 2,
  parameter int                B_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [3:0]        arid,
  input  logic              arvalid,
  output logic              arready,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic [3:0]        rid,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [3:0]        awid,
  input  logic              awvalid,
  output logic              awready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic [3:0]        bid,
  output logic              bvalid,
  input  logic              bready
);

  localparam int                IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0]   MEM_LO     = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]   MEM_HI     = MEM_LO + ((ADDR_W+1)'(MEM_DEPTH) << 3);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3'd7));
  localparam logic [ADDR_W-1:0] BEAT_STEP  = ADDR_W'(4'd8);
  localparam logic [7:0]        R_LAT_C    = 8'(R_LAT);
  localparam logic [7:0]        B_LAT_C    = 8'(B_LAT);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Beat address lies inside the SRAM window (one extra bit avoids wrap at the top).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] wide;
    wide = {1'b0, a};
    return (wide >= MEM_LO) && (wide < MEM_HI);
  endfunction

  // Word index of an in-range, 8-byte aligned beat address.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  logic [63:0] mem_r [MEM_DEPTH];

  // ---------------- read channel state ----------------
  r_state_t          r_state_r, r_state_s;
  logic [ADDR_W-1:0] r_addr_r, r_addr_s, r_step_addr_s;
  logic [7:0]        r_len_r, r_len_s, r_beat_r, r_beat_s, r_cnt_r, r_cnt_s;
  logic [3:0]        rid_r, rid_s;
  logic              arready_r, arready_s, rvalid_r, rvalid_s, rlast_r, rlast_s;
  logic [1:0]        rresp_r, rresp_s;
  logic              r_load_s;
  logic [63:0]       rdata_r;

  // ---------------- write channel state ----------------
  w_state_t          w_state_r, w_state_s;
  logic [ADDR_W-1:0] w_addr_r, w_addr_s;
  logic [7:0]        w_len_r, w_len_s, w_beat_r, w_beat_s, w_cnt_r, w_cnt_s;
  logic [3:0]        w_id_r, w_id_s, bid_r, bid_s;
  logic              w_dec_r, w_dec_s, w_slv_r, w_slv_s;
  logic              awready_r, awready_s, wready_r, wready_s, bvalid_r, bvalid_s;
  logic [1:0]        bresp_r, bresp_s;
  logic              w_we_s, w_final_s;

  assign r_step_addr_s = r_addr_r + BEAT_STEP;
  assign w_final_s     = (w_beat_r == w_len_r);

  assign arready = arready_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign rid     = rid_r;
  assign rlast   = rlast_r;
  assign rvalid  = rvalid_r;
  assign awready = awready_r;
  assign wready  = wready_r;
  assign bresp   = bresp_r;
  assign bid     = bid_r;
  assign bvalid  = bvalid_r;

  // Read FSM next-state and next registered outputs; r_load_s fetches a new beat.
  always_comb begin
    r_state_s = r_state_r;
    r_addr_s  = r_addr_r;
    r_len_s   = r_len_r;
    r_beat_s  = r_beat_r;
    r_cnt_s   = r_cnt_r;
    rid_s     = rid_r;
    arready_s = arready_r;
    rvalid_s  = rvalid_r;
    rlast_s   = rlast_r;
    rresp_s   = rresp_r;
    r_load_s  = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        if (arvalid && arready_r) begin
          r_state_s = R_WAIT;
          r_addr_s  = araddr & ALIGN_MASK;
          r_len_s   = arlen;
          r_beat_s  = 8'd0;
          r_cnt_s   = 8'd0;
          rid_s     = arid;
          arready_s = 1'b0;
        end else begin
          arready_s = 1'b1;
        end
      end
      R_WAIT: begin
        if (r_cnt_r == R_LAT_C) begin
          r_state_s = R_DATA;
          rvalid_s  = 1'b1;
          rlast_s   = (r_len_r == 8'd0);
          rresp_s   = addr_ok(r_addr_r) ? 2'b00 : 2'b11;
          r_load_s  = 1'b1;
        end else begin
          r_cnt_s = r_cnt_r + 8'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_beat_r == r_len_r) begin
            r_state_s = R_IDLE;
            rvalid_s  = 1'b0;
            rlast_s   = 1'b0;
            arready_s = 1'b1;
          end else begin
            r_beat_s  = r_beat_r + 8'd1;
            r_addr_s  = r_step_addr_s;
            rlast_s   = ((r_beat_r + 8'd1) == r_len_r);
            rresp_s   = addr_ok(r_step_addr_s) ? 2'b00 : 2'b11;
            r_load_s  = 1'b1;
          end
        end else begin
          r_load_s = 1'b0;
        end
      end
      default: begin
        r_state_s = R_IDLE;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
        rlast_s   = 1'b0;
      end
    endcase
  end

  // Read-channel registers; reset clears every output and returns to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r <= R_IDLE;
      r_addr_r  <= '0;
      r_len_r   <= 8'd0;
      r_beat_r  <= 8'd0;
      r_cnt_r   <= 8'd0;
      rid_r     <= 4'd0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= 2'b00;
    end else begin
      r_state_r <= r_state_s;
      r_addr_r  <= r_addr_s;
      r_len_r   <= r_len_s;
      r_beat_r  <= r_beat_s;
      r_cnt_r   <= r_cnt_s;
      rid_r     <= rid_s;
      arready_r <= arready_s;
      rvalid_r  <= rvalid_s;
      rlast_r   <= rlast_s;
      rresp_r   <= rresp_s;
    end
  end

  // Read data register; sampling alongside a same-edge write yields the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 64'd0;
    end else if (r_load_s) begin
      rdata_r <= addr_ok(r_addr_s) ? mem_r[word_idx(r_addr_s)] : 64'd0;
    end
  end

  // Write FSM next-state; collects DECERR/SLVERR flags over the whole burst.
  always_comb begin
    w_state_s = w_state_r;
    w_addr_s  = w_addr_r;
    w_len_s   = w_len_r;
    w_beat_s  = w_beat_r;
    w_cnt_s   = w_cnt_r;
    w_id_s    = w_id_r;
    bid_s     = bid_r;
    w_dec_s   = w_dec_r;
    w_slv_s   = w_slv_r;
    awready_s = awready_r;
    wready_s  = wready_r;
    bvalid_s  = bvalid_r;
    bresp_s   = bresp_r;
    w_we_s    = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (awvalid && awready_r) begin
          w_state_s = W_DATA;
          w_addr_s  = awaddr & ALIGN_MASK;
          w_len_s   = awlen;
          w_beat_s  = 8'd0;
          w_id_s    = awid;
          w_dec_s   = 1'b0;
          w_slv_s   = 1'b0;
          awready_s = 1'b0;
          wready_s  = 1'b1;
        end else begin
          awready_s = 1'b1;
        end
      end
      W_DATA: begin
        if (wvalid && wready_r) begin
          w_we_s  = addr_ok(w_addr_r);
          w_dec_s = w_dec_r | ~addr_ok(w_addr_r);
          w_slv_s = w_slv_r | (wlast != w_final_s);
          if (w_final_s) begin
            w_state_s = W_RESP;
            wready_s  = 1'b0;
            w_cnt_s   = 8'd0;
          end else begin
            w_beat_s = w_beat_r + 8'd1;
            w_addr_s = w_addr_r + BEAT_STEP;
          end
        end else begin
          w_we_s = 1'b0;
        end
      end
      W_RESP: begin
        if (bvalid_r) begin
          if (bready) begin
            w_state_s = W_IDLE;
            bvalid_s  = 1'b0;
            awready_s = 1'b1;
          end else begin
            bvalid_s = 1'b1;
          end
        end else if (w_cnt_r == B_LAT_C) begin
          bvalid_s = 1'b1;
          bid_s    = w_id_r;
          bresp_s  = w_dec_r ? 2'b11 : (w_slv_r ? 2'b10 : 2'b00);
        end else begin
          w_cnt_s = w_cnt_r + 8'd1;
        end
      end
      default: begin
        w_state_s = W_IDLE;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
      end
    endcase
  end

  // Write-channel registers; reset clears every output and returns to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      w_addr_r  <= '0;
      w_len_r   <= 8'd0;
      w_beat_r  <= 8'd0;
      w_cnt_r   <= 8'd0;
      w_id_r    <= 4'd0;
      bid_r     <= 4'd0;
      w_dec_r   <= 1'b0;
      w_slv_r   <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      w_state_r <= w_state_s;
      w_addr_r  <= w_addr_s;
      w_len_r   <= w_len_s;
      w_beat_r  <= w_beat_s;
      w_cnt_r   <= w_cnt_s;
      w_id_r    <= w_id_s;
      bid_r     <= bid_s;
      w_dec_r   <= w_dec_s;
      w_slv_r   <= w_slv_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
      bresp_r   <= bresp_s;
    end
  end

  // Byte-enabled SRAM write; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_we_s && !rst) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) begin
          mem_r[word_idx(w_addr_r)][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
AXI4 responder (slave) backing an on-chip SRAM of 64-bit words. It is the other end of the core's AXI4 master port, and is used in simulation and SoC top as main memory. Read and write channels run independent FSMs. Latencies are programmable for bus-timing stress.

Parameters:
ADDR_W, 32, address width
MEM_DEPTH, 4096, number of 64-bit words
BASE_ADDR, 32'h8000_0000, byte address of word 0
R_LAT, 2, cycles from AR handshake to first rvalid, minus 1 (0 allowed)
B_LAT, 1, cycles from last W beat to bvalid, minus 1 (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
araddr  in  ADDR_W  read burst start byte address
arlen  in  8  beats-1
arid  in  4  read id
arvalid  in  1  AR valid
arready  out  1  AR ready
rdata  out  64  read data
rresp  out  2  00 OKAY, 11 DECERR
rid  out  4  echoed arid
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
awaddr  in  ADDR_W  write burst start byte address
awlen  in  8  beats-1
awid  in  4  write id
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  64  write data
wstrb  in  8  byte enables
wlast  in  1  master's last-beat flag
wvalid  in  1  W valid
wready  out  1  W ready
bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
bid  out  4  echoed awid
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset (clk = clock, rst = reset, synchronous, active-high): all outputs 0, including arready/awready. Both FSMs go to IDLE; arready/awready go to 1 on the first cycle after rst deasserts. SRAM contents are not reset.
- Burst type is INCR only. The size signal is not decoded; wstrb selects bytes.
- Beat address is start_addr + 8*beat, aligned down to 8 bytes. Word index = (beat addr - BASE_ADDR)>>3.
- A beat is in range iff BASE_ADDR <= addr < BASE_ADDR + 8*MEM_DEPTH. Each beat is checked independently, so a burst crossing the top boundary mixes OKAY and DECERR beats. On a DECERR beat, rdata=0 and writes are dropped.
- Read FSM: R_IDLE (arready=1) -> on arvalid&arready latch id/addr/len, arready=0 -> R_WAIT counting R_LAT cycles -> R_DATA.
- R_DATA: rvalid=1. Each rvalid&rready advances beat, one beat per cycle when rready is held. rlast=1 iff beat==len. rdata/rresp/rlast/rid stay stable while rvalid&!rready. After the last handshake -> R_IDLE (arready=1 next cycle).
- Read timing: AR handshake at edge N gives first rvalid after edge N+R_LAT+1.
- Write FSM: W_IDLE (awready=1) -> on handshake latch id/addr/len -> W_DATA (wready=1). Each wvalid&wready commits the bytes enabled by wstrb at that edge. After beat awlen completes -> W_RESP.
- The FSM always takes exactly awlen+1 beats. If wlast is high on any beat other than the final one, or low on the final one, the burst's bresp is SLVERR. DECERR has priority over SLVERR if any beat was out of range.
- W_RESP: count B_LAT cycles, then bvalid=1 with bid/bresp held until bready -> W_IDLE.
- W beats presented before the AW handshake are not accepted (wready=0 in W_IDLE).
- Read/write collision on the same word in the same cycle: a read beat sampled in that cycle returns the pre-write data. The next beat sample sees the new data.
- rst mid-burst: both FSMs abort to IDLE next cycle and rvalid/bvalid/wready drop. Beats already committed remain in SRAM.

Test Plan:
- Write 0x8000_0010 len0, wdata 0x1122334455667788, wstrb FF, wlast=1, awid 5 -> bvalid with bresp 00, bid 5. AR same addr, arid 3, R_LAT=2 -> rvalid 3 edges after AR handshake, rdata 0x1122334455667788, rlast=1, rid 3.
- Then write the same addr with wstrb 0x0F, wdata 0xAAAAAAAA_BBBBBBBB -> readback 0x11223344_BBBBBBBB.
- Preload words 0..3 with 0,1,2,3. AR 0x8000_0000 len3 with rready toggling 1,0,1,0 -> 4 beats in order 0,1,2,3; rlast only on beat 3; rdata stable during stalls.
- AR 0x1000_0000 len0 -> rresp 11, rdata 0. AW at the same addr -> bresp 11, SRAM unchanged.
- AW len1 with wlast=1 on beat 0 and 0 on beat 1 -> both beats written, bresp 10.
- Assert rst during beat 1 of a len3 read -> rvalid=0 the next cycle. arready=1 one cycle after rst release; a new AR completes normally.
